// File: rtl/rf_wr_arbiter_if.sv
// Write-port bundle between the two writeback sources, the register file and decode.
// slave is the arbiter's view; master is whoever drives the sources and decode selects.
interface rf_wr_arbiter_if;
    logic        a_valid;
    logic [4:0]  a_regsel;
    logic [31:0] a_data;
    logic        a_full;
    logic        b_valid;
    logic [4:0]  b_regsel;
    logic [31:0] b_data;
    logic        b_ready;
    logic        rf_write;
    logic [4:0]  rf_writeregsel;
    logic [31:0] rf_writedata;
    logic [4:0]  rd1_regsel;
    logic [4:0]  rd2_regsel;
    logic        rd1_pend;
    logic        rd2_pend;
    logic        ovf_err;

    modport slave (
        input  a_valid, a_regsel, a_data, b_valid, b_regsel, b_data, rd1_regsel, rd2_regsel,
        output a_full, b_ready, rf_write, rf_writeregsel, rf_writedata, rd1_pend, rd2_pend, ovf_err
    );
    modport master (
        output a_valid, a_regsel, a_data, b_valid, b_regsel, b_data, rd1_regsel, rd2_regsel,
        input  a_full, b_ready, rf_write, rf_writeregsel, rf_writedata, rd1_pend, rd2_pend, ovf_err
    );
endinterface

// File: rtl/rf_wr_arbiter.sv
// Shares the register-file write port between a buffered, non-stalling ALU source (A)
// and a valid/ready load-return source (B), with RAW pending flags for decode.
module rf_wr_arbiter #(
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    rf_wr_arbiter_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int SW = $clog2(STARVE_MAX + 1);

    typedef struct packed {
        logic [4:0]  regsel;
        logic [31:0] data;
    } wr_req_t;

    wr_req_t          ent_q [DEPTH];
    logic [DEPTH-1:0] vld_q, vld_d;
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [PW:0]      cnt_q, cnt_d;
    logic [SW-1:0]    starve_q, starve_d;
    logic             ovf_q;

    logic [DEPTH-1:0] b_hit, rd1_hit, rd2_hit;
    logic             empty, full, b_blk, b_ok, grant_a, grant_b, push, pop;
    wr_req_t          head;

    for (genvar i = 0; i < DEPTH; i++) begin : g_ent
        assign b_hit[i]   = vld_q[i] && (ent_q[i].regsel == bus.b_regsel);
        assign rd1_hit[i] = vld_q[i] && (ent_q[i].regsel == bus.rd1_regsel);
        assign rd2_hit[i] = vld_q[i] && (ent_q[i].regsel == bus.rd2_regsel);
    end

    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == (PW+1)'(DEPTH));
    assign head  = ent_q[rd_ptr_q];
    // B must wait behind any buffered write to the same register to keep WAW order.
    assign b_blk = |b_hit;
    assign b_ok  = bus.b_valid && !b_blk;

    // Grants are forced low in reset so nothing reaches the rf while rst_n is held.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (rst_n) begin
            if (empty)                                     grant_b = b_ok;
            else if (b_ok && starve_q == SW'(STARVE_MAX)) grant_b = 1'b1;
            else                                           grant_a = 1'b1;
        end
    end

    assign pop  = grant_a;
    assign push = bus.a_valid && (!full || pop);

    always_comb begin
        vld_d = vld_q;
        if (pop)  vld_d[rd_ptr_q] = 1'b0;
        if (push) vld_d[wr_ptr_q] = 1'b1;
        cnt_d = cnt_q;
        if (push && !pop)      cnt_d = cnt_q + 1'b1;
        else if (!push && pop) cnt_d = cnt_q - 1'b1;
        starve_d = starve_q;
        if (grant_b || !bus.b_valid)          starve_d = '0;
        else if (b_blk)                       starve_d = starve_q;
        else if (starve_q != SW'(STARVE_MAX)) starve_d = starve_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
            vld_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            starve_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (push) begin
                ent_q[wr_ptr_q] <= '{regsel: bus.a_regsel, data: bus.a_data};
                wr_ptr_q        <= wr_ptr_q + PW'(1);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
            vld_q    <= vld_d;
            cnt_q    <= cnt_d;
            starve_q <= starve_d;
            ovf_q    <= ovf_q | (bus.a_valid && !push);
        end
    end

    assign bus.a_full         = full;
    assign bus.b_ready        = grant_b;
    assign bus.rf_write       = grant_a | grant_b;
    assign bus.rf_writeregsel = grant_a ? head.regsel : (grant_b ? bus.b_regsel : 5'd0);
    assign bus.rf_writedata   = grant_a ? head.data   : (grant_b ? bus.b_data   : 32'd0);
    assign bus.rd1_pend       = |rd1_hit;
    assign bus.rd2_pend       = |rd2_hit;
    assign bus.ovf_err        = ovf_q;
endmodule

// File: tb/tb_rf_wr_arbiter.sv
// Directed scenarios plus random traffic, every cycle compared against a queue-based
// reference of the arbiter.
module tb_rf_wr_arbiter;
    localparam int DEPTH = 4;
    localparam int SMAX  = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rf_wr_arbiter_if bus();
    rf_wr_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        logic [4:0]  r;
        logic [31:0] d;
    } ent_t;

    ent_t        mq[$];
    int          m_starve;
    bit          m_ovf;
    logic [31:0] tb_rf [32];
    int          n_tests = 0;
    int          n_fail  = 0;

    logic        o_write, o_bready, o_full, o_p1, o_p2, o_ovf;
    logic [4:0]  o_sel;
    logic [31:0] o_data;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_tests++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic bit in_q(input logic [4:0] r);
        foreach (mq[i]) if (mq[i].r == r) return 1'b1;
        return 1'b0;
    endfunction

    task automatic sample();
        o_write  = bus.rf_write;
        o_sel    = bus.rf_writeregsel;
        o_data   = bus.rf_writedata;
        o_bready = bus.b_ready;
        o_full   = bus.a_full;
        o_p1     = bus.rd1_pend;
        o_p2     = bus.rd2_pend;
        o_ovf    = bus.ovf_err;
    endtask

    // One clock: drive at negedge, check against the reference, then advance it.
    task automatic cyc(input bit av, input logic [4:0] ar, input logic [31:0] ad,
                       input bit bv, input logic [4:0] br, input logic [31:0] bd,
                       input logic [4:0] r1 = 5'd0, input logic [4:0] r2 = 5'd0);
        bit ga, gb, bok;
        logic [4:0]  es;
        logic [31:0] ed;
        @(negedge clk);
        bus.a_valid = av; bus.a_regsel = ar; bus.a_data = ad;
        bus.b_valid = bv; bus.b_regsel = br; bus.b_data = bd;
        bus.rd1_regsel = r1; bus.rd2_regsel = r2;
        #1;
        sample();
        bok = bv && !in_q(br);
        ga = 1'b0; gb = 1'b0;
        if (mq.size() == 0)              gb = bok;
        else if (bok && m_starve == SMAX) gb = 1'b1;
        else                             ga = 1'b1;
        es = 5'd0; ed = 32'd0;
        if (ga)      begin es = mq[0].r; ed = mq[0].d; end
        else if (gb) begin es = br;      ed = bd;      end
        chk("rf_write", o_write, ga | gb);
        chk("rf_writeregsel", o_sel, es);
        chk("rf_writedata", o_data, ed);
        chk("b_ready", o_bready, gb);
        chk("a_full", o_full, mq.size() == DEPTH);
        chk("rd1_pend", o_p1, in_q(r1));
        chk("rd2_pend", o_p2, in_q(r2));
        chk("ovf_err", o_ovf, m_ovf);
        if (o_write) tb_rf[o_sel] = o_data;
        @(posedge clk);
        if (ga) void'(mq.pop_front());
        if (av) begin
            if (mq.size() < DEPTH) mq.push_back('{r: ar, d: ad});
            else                   m_ovf = 1'b1;
        end
        if (gb || !bv)       m_starve = 0;
        else if (bok)        m_starve = (m_starve < SMAX) ? m_starve + 1 : SMAX;
    endtask

    task automatic idle(input int n, input logic [4:0] r1 = 5'd0);
        for (int i = 0; i < n; i++) cyc(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, r1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.a_valid = 1'b0; bus.b_valid = 1'b1; bus.b_regsel = 5'd1; bus.b_data = 32'h1;
        mq.delete(); m_starve = 0; m_ovf = 1'b0;
        #1;
        chk("rst_rf_write", bus.rf_write, 0);
        chk("rst_b_ready", bus.b_ready, 0);
        chk("rst_a_full", bus.a_full, 0);
        chk("rst_ovf", bus.ovf_err, 0);
        chk("rst_regsel", bus.rf_writeregsel, 0);
        repeat (2) @(negedge clk);
        bus.b_valid = 1'b0;
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [4:0] seq[$];
        logic [3:0] brdy;
        bit         saw_full;
        int         k;
        bus.a_valid = 0; bus.a_regsel = 0; bus.a_data = 0;
        bus.b_valid = 0; bus.b_regsel = 0; bus.b_data = 0;
        bus.rd1_regsel = 0; bus.rd2_regsel = 0;
        foreach (tb_rf[i]) tb_rf[i] = 32'd0;

        // 1: single A write, one cycle latency
        do_reset();
        cyc(1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'd0);
        idle(1);
        chk("t1_write", o_write, 1);
        chk("t1_sel", o_sel, 5);
        chk("t1_data", o_data, 32'hDEADBEEF);
        idle(1);
        chk("t1_idle", o_write, 0);

        // 2: back-to-back A pushes drain in order
        for (int i = 1; i <= 4; i++) begin
            cyc(1, 5'(i), 32'h100 + i, 0, 5'd0, 32'd0);
            if (o_write) seq.push_back(o_sel);
        end
        for (int i = 0; i < 3; i++) begin
            idle(1);
            if (o_write) seq.push_back(o_sel);
        end
        chk("t2_count", seq.size(), 4);
        for (int i = 0; i < 4 && i < seq.size(); i++) chk("t2_order", seq[i], i + 1);

        // 3: B starved by a busy FIFO is forced through after STARVE_MAX cycles
        idle(2);
        cyc(1, 5'd10, 32'hA0, 0, 5'd0, 32'd0);
        for (int i = 0; i < 4; i++) begin
            cyc(1, 5'(11 + i), 32'hA1 + i, 1, 5'd9, 32'h99);
            brdy[i] = o_bready;
        end
        chk("t3_bready_seq", brdy, 4'b1000);
        chk("t3_b_sel", o_sel, 9);
        idle(6);

        // 4: WAW block on r7
        cyc(1, 5'd7, 32'hA7A7A7A7, 0, 5'd0, 32'd0);
        cyc(0, 5'd0, 32'd0, 1, 5'd7, 32'hB7B7B7B7);
        chk("t4_blocked", o_bready, 0);
        chk("t4_a_data", o_data, 32'hA7A7A7A7);
        cyc(0, 5'd0, 32'd0, 1, 5'd7, 32'hB7B7B7B7);
        chk("t4_granted", o_bready, 1);
        idle(1);
        chk("t4_rf_r7", tb_rf[7], 32'hB7B7B7B7);

        // 5: RAW pending flag on r3
        cyc(1, 5'd3, 32'h33, 0, 5'd0, 32'd0, 5'd3);
        idle(1, 5'd3);
        chk("t5_pend_hi", o_p1, 1);
        idle(1, 5'd3);
        chk("t5_pend_lo", o_p1, 0);

        // random traffic, upstream respects a_full
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 2) != 0) && (mq.size() < DEPTH),
                5'($urandom_range(0, 7)), $urandom,
                $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom,
                5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        end
        idle(8);

        // 6: overfill with B stealing slots, then sticky ovf and mid-drain reset
        saw_full = 1'b0;
        k = 0;
        while (!o_ovf && k < 60) begin
            cyc(1, 5'(1 + (k % 8)), 32'h5000 + k, 1, 5'(16 + (k % 16)), 32'h6000 + k);
            saw_full |= o_full;
            k++;
        end
        chk("t6_saw_full", saw_full, 1);
        chk("t6_ovf_set", o_ovf, 1);
        idle(2);
        chk("t6_ovf_sticky", o_ovf, 1);
        chk("t6_draining", o_write, 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_write", bus.rf_write, 0);
        chk("t6_rst_ovf", bus.ovf_err, 0);
        chk("t6_rst_full", bus.a_full, 0);
        mq.delete(); m_starve = 0; m_ovf = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        seq.delete();
        for (int i = 0; i < 6; i++) begin
            idle(1);
            if (o_write) seq.push_back(o_sel);
        end
        chk("t6_no_write_after", seq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
